// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   WIDTH    : operand/result width (32)
//   INT_MIN  : most negative operand, its magnitude does not fit in 31 bits
//   NEG_ONE  : all-ones operand (-1)
//   state_t  : controller state encoding
//   mag()    : 33-bit zero-extended magnitude of a two's complement operand
package multdiv_ctrl_pkg;
  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, DONE} state_t;

  // |INT_MIN| wraps back to 0x80000000, which is correct when read unsigned.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
    return {1'b0, (x[WIDTH-1] ? (~x + 1'b1) : x)};
  endfunction
endpackage

// File: rtl/multdiv_ctrl_md_step.sv
// One iteration of the shared 33-bit add/subtract datapath.
//   div    : 0 = shift-and-add multiply step, 1 = restoring divide step
//   hi     : running partial product (mult) or partial remainder (div)
//   lo     : multiplier being consumed (mult) or dividend/quotient (div)
//   opnd   : multiplicand magnitude (mult) or divisor magnitude (div)
//   hi_nxt, lo_nxt : register values after this iteration
module md_step
  import multdiv_ctrl_pkg::*;
(
  input  logic             div,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH:0]   opnd,
  output logic [WIDTH:0]   hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);
  logic [WIDTH:0] shl, a, b, sum, sel;

  always_comb begin
    shl = {hi[WIDTH-1:0], lo[WIDTH-1]};
    a   = div ? shl : hi;
    b   = div ? ~opnd : opnd;
    sum = a + b + {{WIDTH{1'b0}}, div};
    sel = hi;
    if (div) begin
      // Both operands stay below 2^32, so bit 32 of the difference is the borrow.
      hi_nxt = sum[WIDTH] ? shl : sum;
      lo_nxt = {lo[WIDTH-2:0], ~sum[WIDTH]};
    end else begin
      sel    = lo[0] ? sum : hi;
      hi_nxt = {1'b0, sel[WIDTH:1]};
      lo_nxt = {sel[0], lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply/divide controller (fixed 33-cycle latency).
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   data_operandA/B     : multiplicand/dividend, multiplier/divisor
//   ctrl_MULT/ctrl_DIV  : one-cycle start pulses (multiply wins on a tie)
//   data_result         : product low word or quotient, held until next DONE
//   data_exception      : mult overflow, div by zero, or INT_MIN / -1
//   data_resultRDY      : one-cycle pulse when result/exception update
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   hi, opnd, hi_nxt;
  logic [WIDTH-1:0] lo, lo_nxt;
  logic             is_div, neg, div_zero, div_ovf;

  logic             start;
  logic [WIDTH:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] pmag, prod;
  logic [WIDTH-1:0] qres;
  logic             mult_ovf;

  assign start = ctrl_MULT | ctrl_DIV;
  assign mag_a = mag(data_operandA);
  assign mag_b = mag(data_operandB);

  md_step u_step (
    .div    (is_div),
    .hi     (hi),
    .lo     (lo),
    .opnd   (opnd),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Sign fix-up of the finished magnitudes.
  always_comb begin
    pmag     = {hi[WIDTH-1:0], lo};
    prod     = neg ? (~pmag + 1'b1) : pmag;
    qres     = neg ? (~lo + 1'b1) : lo;
    // Signed overflow unless the upper 33 product bits are a sign extension.
    mult_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      hi             <= '0;
      lo             <= '0;
      opnd           <= '0;
      is_div         <= 1'b0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A start in any state (re)launches; an in-flight op is dropped silently.
        state    <= ctrl_MULT ? MULT_RUN : DIV_RUN;
        cnt      <= '0;
        hi       <= '0;
        lo       <= ctrl_MULT ? mag_b[WIDTH-1:0] : mag_a[WIDTH-1:0];
        opnd     <= ctrl_MULT ? mag_a : mag_b;
        is_div   <= ~ctrl_MULT;
        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
      end else begin
        case (state)
          MULT_RUN, DIV_RUN: begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) state <= DONE;
          end
          DONE: begin
            state          <= IDLE;
            data_resultRDY <= 1'b1;
            if (!is_div) begin
              data_result    <= prod[WIDTH-1:0];
              data_exception <= mult_ovf;
            end else if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (div_ovf) begin
              data_result    <= INT_MIN;
              data_exception <= 1'b1;
            end else begin
              data_result    <= qres;
              data_exception <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  multdiv_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    longint      due;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  logic   prev_rdy = 1'b0;
  longint t0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain signed arithmetic; returns {exception, result}.
  function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (m) begin
      p = longint'(signed'(a)) * longint'(signed'(b));
      return {(p != longint'(signed'(p[31:0]))), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, a};
    return {1'b0, 32'(signed'(a) / signed'(b))};
  endfunction

  // Drive one start pulse; optionally expect its result 33 cycles later.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [31:0] eres, input logic eexc);
    exp_t e;
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock);
    t0 = longint'($time);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    if (push) begin
      e.res = eres; e.exc = eexc; e.due = t0 + 335;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (data_resultRDY) begin
      chk("rdy_width", {63'd0, prev_rdy}, 64'd0);
      if (sb.size() == 0) begin
        chk("rdy_unexpected", 64'd1, 64'd0);
      end else begin
        chk("result", {32'd0, data_result}, {32'd0, sb[0].res});
        chk("exception", {63'd0, data_exception}, {63'd0, sb[0].exc});
        chk("latency", 64'($time), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
    prev_rdy <= data_resultRDY;
  end

  typedef struct {
    logic        m;
    logic [31:0] a, b, res;
    logic        exc;
  } vec_t;

  vec_t vecs[7] = '{
    '{1'b1, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0},
    '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1},
    '{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0},
    '{1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0},
    '{1'b0, 32'd5,         32'd0,         32'h0000_0000, 1'b1},
    '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
    '{1'b0, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] r;
    logic [31:0] a, b;
    logic        m;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_result", {32'd0, data_result}, 64'd0);
    chk("reset_exc", {63'd0, data_exception}, 64'd0);
    chk("reset_rdy", {63'd0, data_resultRDY}, 64'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].m, ~vecs[i].m, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].exc);
      drain();
    end

    // Both pulses together: multiply wins.
    start_op(1'b1, 1'b1, 32'd6, 32'd3, 1'b1, 32'd18, 1'b0);
    drain();

    // Restart while busy: multiply is abandoned, only the divide reports.
    start_op(1'b1, 1'b0, 32'd3, 32'd3, 1'b0, 32'd0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    chk("hold_result", {32'd0, data_result}, 64'd18);
    chk("hold_exc", {63'd0, data_exception}, 64'd0);
    repeat (4) @(posedge clock);
    start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
    drain();

    // Reset mid-divide: no RDY, outputs cleared.
    start_op(1'b0, 1'b1, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_result", {32'd0, data_result}, 64'd0);
    chk("abort_exc", {63'd0, data_exception}, 64'd0);
    start_op(1'b1, 1'b0, 32'd2, 32'd2, 1'b1, 32'd4, 1'b0);
    drain();

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 10; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      r = model(m, a, b);
      start_op(m, ~m, a, b, 1'b1, r[31:0], r[32]);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
